// File: rtl/usb_buf_pkg.sv
// Shared types and helpers for the USB/AHB byte buffer arbiter.
// Holds the arbiter state encoding, transfer size encodings, the default
// buffer depth and small helpers that turn a size code into byte counts.
package usb_buf_pkg;

    localparam int DEPTH_DEFAULT = 64;

    // AHB transfer size codes (ahb_size)
    localparam logic [1:0] SIZE_B1  = 2'd0;
    localparam logic [1:0] SIZE_B2  = 2'd1;
    localparam logic [1:0] SIZE_B4  = 2'd2;
    localparam logic [1:0] SIZE_BAD = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        AHB_XFER = 2'd1,
        USB_XFER = 2'd2,
        FLUSH    = 2'd3
    } arb_state_t;

    // Number of bytes moved by a size code; the illegal code moves nothing.
    function automatic logic [2:0] bytes_of(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_B1: n = 3'd1;
            SIZE_B2: n = 3'd2;
            SIZE_B4: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Byte-lane enables for a transfer of n bytes starting at lane 0.
    function automatic logic [3:0] lane_mask(input logic [2:0] n);
        logic [3:0] m;
        case (n)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd4:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/buffer_mem.sv
// Byte-wide circular storage for the buffer arbiter.
// One 4-lane write port (per-lane enables) and one 4-lane asynchronous read
// port; lane i addresses base+i, wrapping modulo DEPTH.
module buffer_mem
    import usb_buf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wbe_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Store each enabled lane at its wrapped address; contents are not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe_i[i]) begin
                    mem_q[waddr_i + PTR_W'(i)] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Gather four consecutive bytes starting at the read pointer.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < 4; i++) begin
            rdata_o[8*i +: 8] = mem_q[raddr_i + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/buffer_arbiter.sv
// Arbitrates an AHB port (1/2/4-byte pushes/pops) and a USB port (single
// byte pushes/pops) onto one circular byte buffer.
// Optional build macro BUF_ARB_STATS_EN adds saturating err_count and
// contention_count outputs; without it those ports and counters are absent.
module buffer_arbiter
    import usb_buf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             ahb_req,
    input  logic             ahb_write,
    input  logic [1:0]       ahb_size,
    input  logic [31:0]      ahb_wdata,
    output logic [31:0]      ahb_rdata,
    output logic             ahb_grant,
    output logic             ahb_err,
    input  logic             usb_req,
    input  logic             usb_write,
    input  logic [7:0]       usb_wdata,
    output logic [7:0]       usb_rdata,
    output logic             usb_grant,
    input  logic             flush,
    output logic [PTR_W:0]   occupancy,
    output logic             buf_full,
    output logic             buf_empty
`ifdef BUF_ARB_STATS_EN
    ,
    output logic [15:0]      err_count,
    output logic [15:0]      contention_count
`endif
);

    localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(DEPTH);

    // Keep only the low n byte lanes of a word; the rest read as zero.
    function automatic logic [31:0] keep_lanes(input logic [31:0] data, input logic [2:0] n);
        logic [3:0]  m;
        logic [31:0] r;
        m = lane_mask(n);
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = data[8*i +: 8];
        end
        return r;
    endfunction

    arb_state_t       state_q;
    logic             prio_ahb_q;
    logic             ahb_grant_q;
    logic             ahb_err_q;
    logic             usb_grant_q;
    logic [31:0]      ahb_rdata_q;
    logic [7:0]       usb_rdata_q;

    // Parameters of the transfer that commits at the end of the XFER cycle
    logic             xfer_wr_q;
    logic [2:0]       xfer_n_q;
    logic [31:0]      xfer_wdata_q;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   occ_q, occ_d;

    logic [31:0]      mem_rdata;
    logic [2:0]       ahb_n;
    logic [PTR_W:0]   ahb_n_w;
    logic [PTR_W:0]   free_bytes;
    logic             ahb_ok;
    logic             usb_ok;
    logic             contended;
    logic             ahb_wins;
    logic             commit;
    logic             flush_go;

    assign ahb_n      = bytes_of(ahb_size);
    assign ahb_n_w    = (PTR_W+1)'(ahb_n);
    assign free_bytes = DEPTH_V - occ_q;
    assign ahb_ok     = (ahb_size != SIZE_BAD) &&
                        (ahb_write ? (free_bytes >= ahb_n_w) : (occ_q >= ahb_n_w));
    assign usb_ok     = usb_write ? (occ_q != DEPTH_V) : (occ_q != '0);
    assign contended  = ahb_req && usb_req;
    assign ahb_wins   = ahb_req && (!usb_req || prio_ahb_q);

    // Grants only ever rise during an XFER cycle, so either one means commit.
    assign commit     = ahb_grant_q || usb_grant_q;
    assign flush_go   = (state_q == IDLE) && flush;

    buffer_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (commit && xfer_wr_q),
        .waddr_i (wptr_q),
        .wdata_i (xfer_wdata_q),
        .wbe_i   (lane_mask(xfer_n_q)),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata)
    );

    // Arbiter FSM: decide in IDLE, present registered grant/err/rdata during
    // the one-cycle XFER state, then fall back to IDLE.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q     <= IDLE;
            prio_ahb_q  <= 1'b1;
            ahb_grant_q <= 1'b0;
            ahb_err_q   <= 1'b0;
            usb_grant_q <= 1'b0;
            ahb_rdata_q <= '0;
            usb_rdata_q <= '0;
            xfer_wr_q   <= 1'b0;
            xfer_n_q    <= '0;
        end else begin
            ahb_grant_q <= 1'b0;
            ahb_err_q   <= 1'b0;
            usb_grant_q <= 1'b0;
            ahb_rdata_q <= '0;
            usb_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_q <= FLUSH;
                    end else if (ahb_wins) begin
                        state_q      <= AHB_XFER;
                        xfer_wr_q    <= ahb_write;
                        xfer_n_q     <= ahb_n;
                        xfer_wdata_q <= ahb_wdata;
                        if (contended) prio_ahb_q <= 1'b0;
                        if (ahb_ok) begin
                            ahb_grant_q <= 1'b1;
                            if (!ahb_write) ahb_rdata_q <= keep_lanes(mem_rdata, ahb_n);
                        end else begin
                            ahb_err_q <= 1'b1;
                        end
                    end else if (usb_req) begin
                        state_q      <= USB_XFER;
                        xfer_wr_q    <= usb_write;
                        xfer_n_q     <= 3'd1;
                        xfer_wdata_q <= {24'h0, usb_wdata};
                        if (contended) prio_ahb_q <= 1'b1;
                        if (usb_ok) begin
                            usb_grant_q <= 1'b1;
                            if (!usb_write) usb_rdata_q <= mem_rdata[7:0];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pointer/occupancy next state: flush clears on entry to FLUSH, a granted
    // transfer advances its pointer and occupancy at the end of its cycle.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (flush_go) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else if (commit) begin
            if (xfer_wr_q) begin
                wptr_d = wptr_q + PTR_W'(xfer_n_q);
                occ_d  = occ_q + (PTR_W+1)'(xfer_n_q);
            end else begin
                rptr_d = rptr_q + PTR_W'(xfer_n_q);
                occ_d  = occ_q - (PTR_W+1)'(xfer_n_q);
            end
        end
    end

    // Pointer/occupancy registers; reset abandons any in-flight transfer.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

`ifdef BUF_ARB_STATS_EN
    logic [15:0] err_cnt_q;
    logic [15:0] cont_cnt_q;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            err_cnt_q  <= '0;
            cont_cnt_q <= '0;
        end else begin
            if (ahb_err_q && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
            if ((state_q == IDLE) && !flush && contended && (cont_cnt_q != 16'hFFFF))
                cont_cnt_q <= cont_cnt_q + 16'd1;
        end
    end

    assign err_count        = err_cnt_q;
    assign contention_count = cont_cnt_q;
`endif

    assign ahb_grant = ahb_grant_q;
    assign ahb_err   = ahb_err_q;
    assign usb_grant = usb_grant_q;
    assign ahb_rdata = ahb_rdata_q;
    assign usb_rdata = usb_rdata_q;
    assign occupancy = occ_q;
    assign buf_full  = (occ_q == DEPTH_V);
    assign buf_empty = (occ_q == '0);

endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed bench for buffer_arbiter.
module tb_buffer_arbiter;

    logic        clk = 1'b0;
    logic        nRst;
    logic        ahb_req, ahb_write;
    logic [1:0]  ahb_size;
    logic [31:0] ahb_wdata, ahb_rdata;
    logic        ahb_grant, ahb_err;
    logic        usb_req, usb_write;
    logic [7:0]  usb_wdata, usb_rdata;
    logic        usb_grant;
    logic        flush;
    logic [6:0]  occupancy;
    logic        buf_full, buf_empty;
`ifdef BUF_ARB_STATS_EN
    logic [15:0] err_count, contention_count;
`endif

    int errors = 0;
    int checks = 0;

    buffer_arbiter #(.DEPTH(64), .PTR_W(6)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .ahb_req   (ahb_req),
        .ahb_write (ahb_write),
        .ahb_size  (ahb_size),
        .ahb_wdata (ahb_wdata),
        .ahb_rdata (ahb_rdata),
        .ahb_grant (ahb_grant),
        .ahb_err   (ahb_err),
        .usb_req   (usb_req),
        .usb_write (usb_write),
        .usb_wdata (usb_wdata),
        .usb_rdata (usb_rdata),
        .usb_grant (usb_grant),
        .flush     (flush),
        .occupancy (occupancy),
        .buf_full  (buf_full),
        .buf_empty (buf_empty)
`ifdef BUF_ARB_STATS_EN
        ,
        .err_count        (err_count),
        .contention_count (contention_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One AHB access; returns one cycle after the grant/err cycle (back in IDLE).
    task automatic ahb_do(input logic wr, input logic [1:0] sz, input logic [31:0] wd,
                          input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd,
                          input string tag);
        logic seen;
        ahb_req = 1'b1; ahb_write = wr; ahb_size = sz; ahb_wdata = wd;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (ahb_grant || ahb_err) seen = 1'b1;
        end
        check({tag, "_resp"}, 32'(seen), 32'd1);
        check({tag, "_err"}, 32'(ahb_err), 32'(exp_err));
        check({tag, "_grant"}, 32'(ahb_grant), 32'(!exp_err));
        if (chk_rd) check({tag, "_rdata"}, ahb_rdata, exp_rd);
        ahb_req = 1'b0;
        step();
    endtask

    // One granted USB access.
    task automatic usb_do(input logic wr, input logic [7:0] wd, input logic chk_rd,
                          input logic [7:0] exp_rd, input string tag);
        logic seen;
        usb_req = 1'b1; usb_write = wr; usb_wdata = wd;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (usb_grant) seen = 1'b1;
        end
        check({tag, "_grant"}, 32'(seen), 32'd1);
        if (chk_rd) check({tag, "_rdata"}, 32'(usb_rdata), 32'(exp_rd));
        usb_req = 1'b0;
        step();
    endtask

    // USB request that must never be granted over a window of cycles.
    task automatic usb_withheld(input logic wr, input string tag);
        logic seen;
        usb_req = 1'b1; usb_write = wr; usb_wdata = 8'hEE;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (usb_grant) seen = 1'b1;
        end
        check({tag, "_withheld"}, 32'(seen), 32'd0);
        usb_req = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] wd;
        nRst = 1'b0; flush = 1'b0;
        ahb_req = 1'b0; ahb_write = 1'b0; ahb_size = 2'd0; ahb_wdata = '0;
        usb_req = 1'b0; usb_write = 1'b0; usb_wdata = '0;

        // Reset state
        repeat (3) step();
        check("rst_ahb_grant", 32'(ahb_grant), 32'd0);
        check("rst_ahb_err",   32'(ahb_err),   32'd0);
        check("rst_usb_grant", 32'(usb_grant), 32'd0);
        check("rst_ahb_rdata", ahb_rdata,      32'd0);
        check("rst_usb_rdata", 32'(usb_rdata), 32'd0);
        check("rst_occ",       32'(occupancy), 32'd0);
        check("rst_empty",     32'(buf_empty), 32'd1);
        check("rst_full",      32'(buf_full),  32'd0);
`ifdef BUF_ARB_STATS_EN
        check("rst_errcnt",  32'(err_count),        32'd0);
        check("rst_contcnt", 32'(contention_count), 32'd0);
`endif
        nRst = 1'b1;
        step();

        // Word write, four byte reads in little-endian order
        ahb_do(1'b1, 2'd2, 32'hDDCCBBAA, 1'b0, 1'b0, 32'h0, "w4");
        check("w4_occ", 32'(occupancy), 32'd4);
        usb_do(1'b0, 8'h00, 1'b1, 8'hAA, "rd0");
        check("rd0_occ", 32'(occupancy), 32'd3);
        usb_do(1'b0, 8'h00, 1'b1, 8'hBB, "rd1");
        check("rd1_occ", 32'(occupancy), 32'd2);
        usb_do(1'b0, 8'h00, 1'b1, 8'hCC, "rd2");
        check("rd2_occ", 32'(occupancy), 32'd1);
        usb_do(1'b0, 8'h00, 1'b1, 8'hDD, "rd3");
        check("rd3_occ",   32'(occupancy), 32'd0);
        check("rd3_empty", 32'(buf_empty), 32'd1);

        // Contention: AHB first after reset, then alternating
        ahb_req = 1'b1; ahb_write = 1'b1; ahb_size = 2'd0; ahb_wdata = 32'h11;
        usb_req = 1'b1; usb_write = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("rr%0d_ahb", c), 32'(ahb_grant), 32'((c % 4) == 0));
            check($sformatf("rr%0d_usb", c), 32'(usb_grant), 32'((c % 4) == 2));
            if ((c % 4) == 2) check($sformatf("rr%0d_rdata", c), 32'(usb_rdata), 32'h11);
        end
        ahb_req = 1'b0; usb_req = 1'b0;
        step();
        check("rr_occ", 32'(occupancy), 32'd0);
`ifdef BUF_ARB_STATS_EN
        check("rr_contcnt", 32'(contention_count), 32'd4);
`endif

        // Fill to 63 bytes with an incrementing byte pattern
        b = 8'd0;
        for (int k = 0; k < 15; k++) begin
            wd = {b + 8'd3, b + 8'd2, b + 8'd1, b};
            ahb_do(1'b1, 2'd2, wd, 1'b0, 1'b0, 32'h0, $sformatf("fill%0d", k));
            b = b + 8'd4;
        end
        ahb_do(1'b1, 2'd1, 32'h00003D3C, 1'b0, 1'b0, 32'h0, "fill_h");
        ahb_do(1'b1, 2'd0, 32'h0000003E, 1'b0, 1'b0, 32'h0, "fill_b");
        check("fill_occ63", 32'(occupancy), 32'd63);
        ahb_do(1'b1, 2'd1, 32'h0000BEEF, 1'b1, 1'b0, 32'h0, "ovf_h");
        check("ovf_occ63", 32'(occupancy), 32'd63);
        ahb_do(1'b1, 2'd0, 32'h0000003F, 1'b0, 1'b0, 32'h0, "last_b");
        check("full_occ", 32'(occupancy), 32'd64);
        check("full_flag", 32'(buf_full), 32'd1);
        usb_withheld(1'b1, "usb_full");
        check("full_occ_keep", 32'(occupancy), 32'd64);

        // Drain and confirm every byte came back in order
        b = 8'd0;
        for (int k = 0; k < 16; k++) begin
            wd = {b + 8'd3, b + 8'd2, b + 8'd1, b};
            ahb_do(1'b0, 2'd2, 32'h0, 1'b0, 1'b1, wd, $sformatf("drain%0d", k));
            b = b + 8'd4;
        end
        check("drain_empty", 32'(buf_empty), 32'd1);

        // Pointers sit at 6; move both to 62
        for (int k = 0; k < 14; k++) begin
            ahb_do(1'b1, 2'd2, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, $sformatf("adv_w%0d", k));
            ahb_do(1'b0, 2'd2, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5, $sformatf("adv_r%0d", k));
        end

        // Word crossing address 63 -> 0
        ahb_do(1'b1, 2'd2, 32'h44332211, 1'b0, 1'b0, 32'h0, "wrap_w");
        ahb_do(1'b0, 2'd2, 32'h0, 1'b0, 1'b1, 32'h44332211, "wrap_r");
        ahb_do(1'b1, 2'd0, 32'h00000077, 1'b0, 1'b0, 32'h0, "wrap_w2");
        usb_do(1'b0, 8'h00, 1'b1, 8'h77, "wrap_r2");
        check("wrap_occ", 32'(occupancy), 32'd0);
        // Size-2 read must return zero in the upper lanes
        ahb_do(1'b1, 2'd2, 32'h87654321, 1'b0, 1'b0, 32'h0, "half_w");
        ahb_do(1'b0, 2'd1, 32'h0, 1'b0, 1'b1, 32'h00004321, "half_r");
        check("half_occ", 32'(occupancy), 32'd2);

        // Flush with 10 bytes stored
        ahb_do(1'b1, 2'd2, 32'h03020100, 1'b0, 1'b0, 32'h0, "fl_w0");
        ahb_do(1'b1, 2'd2, 32'h07060504, 1'b0, 1'b0, 32'h0, "fl_w1");
        check("fl_occ10", 32'(occupancy), 32'd10);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_occ0",  32'(occupancy), 32'd0);
        check("fl_empty", 32'(buf_empty), 32'd1);
        check("fl_nogrant", 32'(ahb_grant | usb_grant), 32'd0);
        step();
        usb_withheld(1'b0, "usb_empty");

        // Illegal size
        ahb_do(1'b1, 2'd3, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0, "bad_w");
        ahb_do(1'b0, 2'd3, 32'h0, 1'b1, 1'b0, 32'h0, "bad_r");
        check("bad_occ", 32'(occupancy), 32'd0);
`ifdef BUF_ARB_STATS_EN
        check("errcnt", 32'(err_count), 32'd3);
        check("contcnt_keep", 32'(contention_count), 32'd4);
`endif

        // Reset in the grant cycle aborts the commit
        ahb_req = 1'b1; ahb_write = 1'b1; ahb_size = 2'd2; ahb_wdata = 32'hCAFEF00D;
        step();
        check("abort_grant", 32'(ahb_grant), 32'd1);
        nRst = 1'b0;
        ahb_req = 1'b0;
        step();
        nRst = 1'b1;
        check("abort_occ",   32'(occupancy), 32'd0);
        check("abort_gnt0",  32'(ahb_grant), 32'd0);
        step();
        check("abort_occ2",  32'(occupancy), 32'd0);
        check("abort_empty", 32'(buf_empty), 32'd1);
`ifdef BUF_ARB_STATS_EN
        check("abort_errcnt",  32'(err_count),        32'd0);
        check("abort_contcnt", 32'(contention_count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
